// File: rtl/beam_pkg.sv
// Shared definitions for the beamformer sample-alignment buffer: default sizes,
// sweep FSM encoding and the channel-slice packing helper.
package beam_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Bit offset of channel ch inside a bus packed as ch * width.
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/beam_dpram.sv
// Simple dual-port RAM, one write and one synchronous read port.
// The address MSB selects the ping-pong bank.
module beam_dpram #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the storage array has no reset so it maps onto block RAM; validity
    // is tracked by the full flags in the parent, not by the contents.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        q <= mem[raddr];
    end

endmodule

// File: rtl/beam_sample_buffer.sv
// Ping-pong frame buffer: one bank fills from the ADC while the other is swept
// out with a per-channel read offset, feeding the delay-and-sum stage.
module beam_sample_buffer
    import beam_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH*ADDR_W-1:0] delays,
    output logic                     out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0]        wr_ptr;
    logic                     wr_bank;
    logic                     rd_bank;
    logic [1:0]               full;
    logic [1:0]               full_next;
    state_t                   state;
    logic [ADDR_W-1:0]        idx;
    logic                     drain_cnt;
    logic [NUM_CH*ADDR_W-1:0] delays_q;

    logic [ADDR_W:0]          rd_addr [NUM_CH];
    logic [DATA_W-1:0]        ram_q   [NUM_CH];
    logic                     s1_valid, s1_last;
    logic                     s2_valid, s2_last;

    logic wr_en, frame_done, sweep_done;

    assign in_ready   = load & ~full[wr_bank];
    assign wr_en      = in_valid & in_ready;
    assign frame_done = wr_en & (wr_ptr == LAST_IDX);
    assign sweep_done = (state == DRAIN) & drain_cnt;
    assign busy       = (state != IDLE);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        beam_dpram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W + 1)
        ) u_ram (
            .clock (clock),
            .we    (wr_en),
            .waddr ({wr_bank, wr_ptr}),
            .wdata (in_data[ch_lsb(c, DATA_W) +: DATA_W]),
            .raddr (rd_addr[c]),
            .q     (ram_q[c])
        );
    end

    // The sweep only ever clears the bank it reads, and a full bank is never
    // written, so both updates can land on the same edge without conflict.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        full_next = full;
        if (sweep_done) full_next[rd_bank] = 1'b0;
        if (frame_done) full_next[wr_bank] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every block sees
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            wr_bank  <= 1'b0;
            full     <= '0;
            overflow <= 1'b0;
        end else begin
            full <= full_next;
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                if (frame_done) wr_bank <= ~wr_bank;
            end
            if (in_valid && load && (&full)) overflow <= 1'b1;
        end
    end

    // Banks fill and drain in the same order, so the toggling rd_bank always
    // points at the oldest full bank.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            drain_cnt <= 1'b0;
            rd_bank   <= 1'b0;
            delays_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (full != 2'b00)) begin
                        state    <= READ;
                        delays_q <= delays;
                        idx      <= '0;
                    end
                end
                READ: begin
                    idx <= idx + ADDR_W'(1);
                    if (idx == LAST_IDX) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state   <= IDLE;
                        rd_bank <= ~rd_bank;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address register -> RAM q -> output register: first word three edges after start.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) rd_addr[c] <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_addr[c] <= {rd_bank, idx + delays_q[ch_lsb(c, ADDR_W) +: ADDR_W]};
            end
            s1_valid  <= (state == READ);
            s1_last   <= (state == READ) && (idx == LAST_IDX);
            s2_valid  <= s1_valid;
            s2_last   <= s1_last;
            out_valid <= s2_valid;
            out_last  <= s2_valid & s2_last;
            if (s2_valid) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    out_data[ch_lsb(c, DATA_W) +: DATA_W] <= ram_q[c];
                end
            end
            done <= out_valid & out_last;
        end
    end

endmodule

// File: tb/tb_beam_sample_buffer.sv
// Directed bench for beam_sample_buffer: table of frame/sweep vectors plus
// hand-written sequences for reset, overflow, ignored starts and overlap.
module tb_beam_sample_buffer;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [11:0] delays = '0;
    logic        out_valid, out_last, busy, done, overflow;
    logic [15:0] out_data;

    int n_cmp  = 0;
    int n_fail = 0;

    beam_sample_buffer dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .load      (load),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .delays    (delays),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  base;
        logic [3:0]  step;
        logic [11:0] dl;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sample written for channel c at frame index i is base + i + step*c (4 bits).
    function automatic logic [15:0] exp_word(input logic [3:0] base, input logic [3:0] step,
                                             input logic [11:0] dl, input int k);
        logic [15:0] w;
        w = '0;
        for (int c = 0; c < 4; c++) begin
            int a;
            a = (k + int'(dl[c*3 +: 3])) % 8;
            w[c*4 +: 4] = 4'(int'(base) + a + int'(step) * c);
        end
        return w;
    endfunction

    task automatic write_frame(input logic [3:0] base, input logic [3:0] step, input int count);
        for (int i = 0; i < count; i++) begin
            int t;
            in_valid = 1'b1;
            for (int c = 0; c < 4; c++) in_data[c*4 +: 4] = 4'(int'(base) + i + int'(step) * c);
            t = 0;
            while (!in_ready && t < 50) begin
                @(posedge clock); #1;
                t++;
            end
            if (t == 50) check("in_ready_wait", 32'(in_ready), 32'd1);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_sweep(input logic [3:0] base, input logic [3:0] step, input logic [11:0] dl,
                             input logic [15:0] exp_first, input logic [15:0] exp_last,
                             input bit extra_start, input string name);
        int n, dn, last_cyc;
        n = 0; dn = 0; last_cyc = -10;
        delays = dl;
        start  = 1'b1;
        @(posedge clock); #1;
        start  = 1'b0;
        delays = ~dl;
        check({name, "_busy"}, 32'(busy), 32'd1);
        for (int cyc = 1; cyc <= 16; cyc++) begin
            start = (extra_start && cyc == 3);
            @(posedge clock); #1;
            if (out_valid) begin
                if (n == 0) begin
                    check({name, "_latency"}, 32'(cyc), 32'd3);
                    check({name, "_first"}, 32'(out_data), 32'(exp_first));
                end
                if (n == 7) check({name, "_lastword"}, 32'(out_data), 32'(exp_last));
                check({name, "_word"}, 32'(out_data), 32'(exp_word(base, step, dl, n)));
                check({name, "_out_last"}, 32'(out_last), 32'(n == 7));
                if (out_last) last_cyc = cyc;
                n++;
            end
            if (done) begin
                dn++;
                check({name, "_done_timing"}, 32'(cyc), 32'(last_cyc + 1));
            end
        end
        start = 1'b0;
        check({name, "_words"}, 32'(n), 32'd8);
        check({name, "_dones"}, 32'(dn), 32'd1);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs[3];

    initial begin
        vecs[0] = '{base: 4'd0, step: 4'd0, dl: {3'd0, 3'd0, 3'd0, 3'd0},
                    exp_first: 16'h0000, exp_last: 16'h7777};
        vecs[1] = '{base: 4'd0, step: 4'd0, dl: {3'd3, 3'd2, 3'd1, 3'd0},
                    exp_first: 16'h3210, exp_last: 16'h2107};
        vecs[2] = '{base: 4'd5, step: 4'd4, dl: {3'd7, 3'd0, 3'd5, 3'd2},
                    exp_first: 16'h8DE7, exp_last: 16'h74D6};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clock); #1;
        load = 1'b1;
        #1;
        check("load_in_ready", 32'(in_ready), 32'd1);

        // Partial stale frame, then reset mid-fill: the refill must win.
        write_frame(4'd8, 4'd1, 3);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clock); #1;

        for (int v = 0; v < 3; v++) begin
            write_frame(vecs[v].base, vecs[v].step, 8);
            check("after_fill_in_ready", 32'(in_ready), 32'd1);
            run_sweep(vecs[v].base, vecs[v].step, vecs[v].dl,
                      vecs[v].exp_first, vecs[v].exp_last, 1'b0, $sformatf("vec%0d", v));
        end

        // start with no full bank is ignored
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("empty_start_busy", 32'(busy), 32'd0);
        repeat (4) @(posedge clock);
        #1;
        check("empty_start_valid", 32'(out_valid), 32'd0);
        check("empty_start_busy2", 32'(busy), 32'd0);

        // start during READ is ignored: still exactly one sweep
        write_frame(4'd0, 4'd0, 8);
        run_sweep(4'd0, 4'd0, {3'd3, 3'd2, 3'd1, 3'd0}, 16'h3210, 16'h2107, 1'b1, "busy_start");

        // Both banks full: back-pressure and sticky overflow
        check("pre_ovf", 32'(overflow), 32'd0);
        write_frame(4'd1, 4'd2, 8);
        write_frame(4'd2, 4'd3, 8);
        in_valid = 1'b1;
        #1;
        check("both_full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        check("ovf_set", 32'(overflow), 32'd1);
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("ovf_sticky", 32'(overflow), 32'd1);
        run_sweep(4'd1, 4'd2, 12'd0, 16'h7531, 16'hECA8, 1'b0, "ovf_sweep");
        check("after_drain_in_ready", 32'(in_ready), 32'd1);
        check("ovf_still", 32'(overflow), 32'd1);

        // Continuous load overlapping back-to-back sweeps
        fork
            run_sweep(4'd2, 4'd3, 12'd0, 16'hB852, 16'h2FC9, 1'b0, "ovl_a");
            write_frame(4'd3, 4'd1, 8);
        join
        fork
            run_sweep(4'd3, 4'd1, 12'd0, 16'h6543, 16'hDCBA, 1'b0, "ovl_b");
            write_frame(4'd4, 4'd0, 8);
        join
        run_sweep(4'd4, 4'd0, 12'd0, 16'h4444, 16'hBBBB, 1'b0, "ovl_c");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
